// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
// Holds the FSM state encoding, data widths and the alignment check.
package dmem_pkg;

  localparam int DW_BITS  = 64;
  localparam int OFS_BITS = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  function automatic logic is_aligned(
    input logic [DW_BITS-1:0] addr
  );
    return addr[OFS_BITS-1:0] == '0;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between MEM stage and memory.
// The master drives requests; the slave returns ready and responses.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic               req_valid;
  logic               req_write;
  logic [DW_BITS-1:0] req_addr;
  logic [DW_BITS-1:0] req_wdata;
  logic               req_ready;
  logic               rsp_valid;
  logic [DW_BITS-1:0] rsp_rdata;
  logic               rsp_err;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Doubleword storage: synchronous write, registered read, async clear.
// Words 0..7 are exported for debug visibility.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DEPTH_DW = 64,
  localparam int IW = (DEPTH_DW > 1) ? $clog2(DEPTH_DW) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    commit_i,
  input  logic                    we_i,
  input  logic                    ld_i,
  input  logic [IW-1:0]           idx_i,
  input  logic [DW_BITS-1:0]      wdata_i,
  output logic [DW_BITS-1:0]      rdata_o,
  output logic [7:0][DW_BITS-1:0] words_o
);

  logic [DW_BITS-1:0] mem_q [DEPTH_DW];
  logic [DW_BITS-1:0] rdata_q;
  logic [DW_BITS-1:0] rdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_DW; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // Stores and faulting accesses return zero data.
  always_comb begin
    rdata_d = '0;
    if (ld_i) begin
      rdata_d = mem_q[idx_i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (commit_i) begin
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    words_o = '0;
    for (int i = 0; i < 8; i++) begin
      words_o[i] = mem_q[i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory target with fixed wait latency before response.
// One transaction in flight; response is a single-cycle pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_DW = 64,
  parameter int LATENCY  = 2
) (
  input  logic               clock,
  input  logic               reset,
  dmem_responder_if.slave    bus,
  output logic               busy,
  output logic [DW_BITS-1:0] e1,
  output logic [DW_BITS-1:0] e2,
  output logic [DW_BITS-1:0] e3,
  output logic [DW_BITS-1:0] e4,
  output logic [DW_BITS-1:0] e5,
  output logic [DW_BITS-1:0] e6,
  output logic [DW_BITS-1:0] e7,
  output logic [DW_BITS-1:0] e8
);

  localparam int IW = (DEPTH_DW > 1) ? $clog2(DEPTH_DW) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               rdy_q, rdy_d;
  logic               wr_q;
  logic [DW_BITS-1:0] addr_q;
  logic [DW_BITS-1:0] wdata_q;
  logic               err_q;

  logic accept;
  logic commit;
  logic in_range;
  logic ok;

  logic [7:0][DW_BITS-1:0] words;

  assign accept   = bus.req_valid & rdy_q;
  assign commit   = (state_q == WAIT) && (cnt_q == 4'd0);
  assign in_range = addr_q[DW_BITS-1:OFS_BITS] < (DW_BITS-OFS_BITS)'(DEPTH_DW);
  assign ok       = is_aligned(addr_q) & in_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (accept) begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
          rdy_d   = 1'b0;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
      end
      default: begin
        state_d = IDLE;
        rdy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= bus.req_write;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (commit) begin
      err_q <= ~ok;
    end
  end

  dmem_array #(
    .DEPTH_DW (DEPTH_DW)
  ) u_array (
    .clk      (clock),
    .rst_n    (reset),
    .commit_i (commit),
    .we_i     (commit & wr_q & ok),
    .ld_i     (~wr_q & ok),
    .idx_i    (addr_q[IW+OFS_BITS-1:OFS_BITS]),
    .wdata_i  (wdata_q),
    .rdata_o  (bus.rsp_rdata),
    .words_o  (words)
  );

  assign bus.req_ready = rdy_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = err_q;
  assign busy          = (state_q != IDLE);

  assign e1 = words[0];
  assign e2 = words[1];
  assign e3 = words[2];
  assign e4 = words[3];
  assign e5 = words[4];
  assign e6 = words[5];
  assign e7 = words[6];
  assign e8 = words[7];

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder at LATENCY 1, 2 and 15 against an array model.
// Random and directed loads/stores; timing, errors and reset are checked.
module tb_dmem_responder;

  localparam int ND = 3;
  localparam int DEPTH = 64;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 15;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v   [ND];
  logic        w   [ND];
  logic [63:0] a   [ND];
  logic [63:0] d   [ND];
  logic        rdy [ND];
  logic        rv  [ND];
  logic        er  [ND];
  logic        bz  [ND];
  logic [63:0] rd  [ND];
  logic [63:0] ev  [ND][8];

  logic [63:0] mdl [ND][DEPTH];
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    dmem_responder_if bus ();
    assign bus.req_valid = v[g];
    assign bus.req_write = w[g];
    assign bus.req_addr  = a[g];
    assign bus.req_wdata = d[g];
    assign rdy[g] = bus.req_ready;
    assign rv[g]  = bus.rsp_valid;
    assign er[g]  = bus.rsp_err;
    assign rd[g]  = bus.rsp_rdata;
    dmem_responder #(
      .DEPTH_DW (DEPTH),
      .LATENCY  ((g == 0) ? 1 : (g == 1) ? 2 : 15)
    ) u_dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus),
      .busy  (bz[g]),
      .e1    (ev[g][0]),
      .e2    (ev[g][1]),
      .e3    (ev[g][2]),
      .e4    (ev[g][3]),
      .e5    (ev[g][4]),
      .e6    (ev[g][5]),
      .e7    (ev[g][6]),
      .e8    (ev[g][7])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < ND; k++)
      for (int i = 0; i < DEPTH; i++)
        mdl[k][i] = '0;
  endtask

  task automatic txn(input int k, input bit wr,
                     input logic [63:0] adr, input logic [63:0] wd);
    int n;
    int bcnt;
    int lat;
    bit err;
    logic [63:0] expd;
    lat  = lat_of(k);
    err  = (adr[2:0] != 3'd0) || (adr[63:3] >= 61'(DEPTH));
    expd = (!wr && !err) ? mdl[k][adr[8:3]] : 64'd0;
    @(negedge clk);
    n = 0;
    while (!rdy[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(rdy[k]), 64'd1);
    v[k] = 1'b1;
    w[k] = wr;
    a[k] = adr;
    d[k] = wd;
    @(posedge clk);
    #1;
    v[k] = 1'b0;
    bcnt = int'(bz[k]);
    n = 0;
    while (!rv[k] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      bcnt += int'(bz[k]);
    end
    chk("rsp_latency", 64'(n), 64'(lat));
    chk("rsp_err", 64'(er[k]), 64'(err));
    chk("rsp_rdata", rd[k], expd);
    if (wr && !err) mdl[k][adr[8:3]] = wd;
    @(posedge clk);
    #1;
    bcnt += int'(bz[k]);
    chk("rsp_one_cycle", 64'(rv[k]), 64'd0);
    chk("busy_cycles", 64'(bcnt), 64'(lat + 1));
    chk("ready_back", 64'(rdy[k]), 64'd1);
    for (int i = 0; i < 8; i++) chk("e_view", ev[k][i], mdl[k][i]);
  endtask

  function automatic logic [63:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 64'($urandom_range(0, DEPTH - 1)) << 3;
    if (r == 7) return (64'($urandom_range(0, DEPTH - 1)) << 3)
                       | 64'($urandom_range(1, 7));
    return {$urandom, $urandom} | 64'h1000;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_edge [$];
    int edge_no;
    int pulses;
    bit pre;
    for (int k = 0; k < ND; k++) begin
      v[k] = 1'b0; w[k] = 1'b0; a[k] = '0; d[k] = '0;
    end
    clear_model();

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < ND; k++) begin
      chk("rst_ready", 64'(rdy[k]), 64'd0);
      chk("rst_rsp_valid", 64'(rv[k]), 64'd0);
      chk("rst_rdata", rd[k], 64'd0);
      chk("rst_err", 64'(er[k]), 64'd0);
      chk("rst_busy", 64'(bz[k]), 64'd0);
      chk("rst_e8", ev[k][7], 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < ND; k++) chk("ready_rise", 64'(rdy[k]), 64'd1);

    txn(1, 1'b1, 64'h10, 64'hDEADBEEF_00000001);
    chk("e3_store", ev[1][2], 64'hDEADBEEF_00000001);
    txn(1, 1'b0, 64'h10, 64'h0);
    txn(1, 1'b1, 64'h0C, 64'h1234);
    txn(1, 1'b1, 64'h200, 64'h5678);
    txn(1, 1'b0, 64'h10, 64'h0);

    txn(2, 1'b1, 64'h38, 64'hA5A5_0000_FFFF_0038);
    txn(2, 1'b0, 64'h38, 64'h0);
    txn(2, 1'b0, 64'h38, 64'h0);

    @(negedge clk);
    v[1] = 1'b1; w[1] = 1'b1; a[1] = 64'h0; d[1] = 64'h55;
    @(posedge clk);
    #1;
    v[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(bz[1]), 64'd0);
    chk("midrst_ready", 64'(rdy[1]), 64'd0);
    chk("midrst_e3", ev[1][2], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    pulses = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      pulses += int'(rv[1]);
    end
    chk("midrst_no_rsp", 64'(pulses), 64'd0);
    chk("midrst_e1", ev[1][0], 64'd0);

    txn(0, 1'b1, 64'h18, 64'h0BAD_F00D_1111_2222);
    @(negedge clk);
    v[0] = 1'b1; w[0] = 1'b0; a[0] = 64'h18; d[0] = '0;
    pulses = 0;
    for (edge_no = 1; edge_no <= 20; edge_no++) begin
      pre = rdy[0];
      @(posedge clk);
      if (pre) acc_edge.push_back(edge_no);
      #1;
      if (rv[0]) begin
        pulses++;
        chk("stream_rdata", rd[0], mdl[0][3]);
      end
      @(negedge clk);
    end
    v[0] = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      pulses += int'(rv[0]);
    end
    chk("stream_accepts", 64'(acc_edge.size()), 64'd7);
    chk("stream_pulses", 64'(pulses), 64'(acc_edge.size()));
    for (int i = 1; i < acc_edge.size(); i++)
      chk("stream_spacing", 64'(acc_edge[i] - acc_edge[i-1]), 64'd3);

    for (int t = 0; t < 60; t++) begin
      txn(int'($urandom_range(0, ND - 1)), 1'($urandom_range(0, 1)),
          rand_addr(), {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
